// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order commit queue sitting between decode/dispatch and the
// register file. Each issued instruction is granted a tag (the tail slot).
// The ALU and the load/store buffer write results back by tag. The oldest
// entry retires one per cycle once its result is present. A committing
// branch whose actual direction differs from its prediction flushes the
// whole queue and requests a refetch.
//
// Optional feature (compile-time macro ROB_BYPASS_EN):
//   When defined, operand queries also match the ALU/LSB writeback strobes
//   presented in the same cycle, so a result is visible to dispatch in the
//   cycle it is produced. When undefined, queries see only stored entries.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-high reset
//   rdy                       global enable; low freezes all state
//   ID_valid/ID_reg_dest/
//   ID_is_branch/ID_pred_taken allocation request from decode
//   ID_tag, rob_full          tag granted this cycle, queue-full stall
//   q1_tag/q2_tag -> q1_ready/q1_data, q2_ready/q2_data   operand lookups
//   ALU_valid/tag/data/taken/target   ALU writeback (with branch outcome)
//   LSB_valid/tag/data        load/store writeback
//   ROB_data_valid/reg_dest/tag/data  registered commit bus to regfile
//   clear, clear_pc           registered one-cycle flush pulse + refetch PC
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int TAG_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              ID_valid,
    input  logic [4:0]        ID_reg_dest,
    input  logic              ID_is_branch,
    input  logic              ID_pred_taken,
    output logic [TAG_W-1:0]  ID_tag,
    output logic              rob_full,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_data,
    output logic [DATA_W-1:0] q2_data,
    input  logic              ALU_valid,
    input  logic [TAG_W-1:0]  ALU_tag,
    input  logic [DATA_W-1:0] ALU_data,
    input  logic              ALU_taken,
    input  logic [31:0]       ALU_target,
    input  logic              LSB_valid,
    input  logic [TAG_W-1:0]  LSB_tag,
    input  logic [DATA_W-1:0] LSB_data,
    output logic              ROB_data_valid,
    output logic [4:0]        ROB_reg_dest,
    output logic [TAG_W-1:0]  ROB_tag,
    output logic [DATA_W-1:0] ROB_data,
    output logic              clear,
    output logic [31:0]       clear_pc
);

    localparam int ROB_SIZE = 1 << TAG_W;
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W + 1)'(ROB_SIZE);

    logic [TAG_W-1:0]  head;
    logic [TAG_W-1:0]  tail;
    logic [TAG_W:0]    count;

    logic [ROB_SIZE-1:0] busy;
    logic [ROB_SIZE-1:0] ready;
    logic [ROB_SIZE-1:0] is_branch;
    logic [ROB_SIZE-1:0] pred_taken;
    logic [ROB_SIZE-1:0] taken;
    logic [4:0]          reg_dest [ROB_SIZE];
    logic [DATA_W-1:0]   data     [ROB_SIZE];
    logic [31:0]         target   [ROB_SIZE];

    logic alloc_fire;
    logic commit_fire;
    logic mispredict;

    // Full is judged on the current count, so a commit in the same cycle
    // does not free a slot for allocation until the next cycle.
    assign rob_full    = (count == FULL_COUNT);
    assign ID_tag      = tail;
    assign alloc_fire  = rdy && ID_valid && !rob_full;
    assign commit_fire = busy[head] && ready[head];
    assign mispredict  = commit_fire && is_branch[head] && (taken[head] != pred_taken[head]);

    // Operand lookups. With the bypass enabled, a strobe carrying the
    // queried tag overrides the stored entry, the ALU taking priority.
    always_comb begin
        q1_ready = busy[q1_tag] && ready[q1_tag];
        q1_data  = data[q1_tag];
        q2_ready = busy[q2_tag] && ready[q2_tag];
        q2_data  = data[q2_tag];
`ifdef ROB_BYPASS_EN
        if (ALU_valid && (ALU_tag == q1_tag)) begin
            q1_ready = 1'b1;
            q1_data  = ALU_data;
        end else if (LSB_valid && (LSB_tag == q1_tag)) begin
            q1_ready = 1'b1;
            q1_data  = LSB_data;
        end
        if (ALU_valid && (ALU_tag == q2_tag)) begin
            q2_ready = 1'b1;
            q2_data  = ALU_data;
        end else if (LSB_valid && (LSB_tag == q2_tag)) begin
            q2_ready = 1'b1;
            q2_data  = LSB_data;
        end
`endif
    end

    // Queue state and registered commit/flush outputs. Within the normal
    // path, writebacks are applied before the commit so that retiring the
    // head always clears its busy/ready bits even if it is written again.
    // A mispredict discards the same-cycle allocation and writebacks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            busy           <= '0;
            ready          <= '0;
            is_branch      <= '0;
            pred_taken     <= '0;
            taken          <= '0;
            for (int i = 0; i < ROB_SIZE; i++) begin
                reg_dest[i] <= '0;
                data[i]     <= '0;
                target[i]   <= '0;
            end
            ROB_data_valid <= 1'b0;
            ROB_reg_dest   <= '0;
            ROB_tag        <= '0;
            ROB_data       <= '0;
            clear          <= 1'b0;
            clear_pc       <= '0;
        end else if (!rdy) begin
            ROB_data_valid <= 1'b0;
            clear          <= 1'b0;
        end else begin
            ROB_data_valid <= 1'b0;
            clear          <= 1'b0;
            if (mispredict) begin
                ROB_data_valid <= 1'b1;
                ROB_reg_dest   <= '0;
                ROB_tag        <= head;
                ROB_data       <= data[head];
                clear          <= 1'b1;
                clear_pc       <= target[head];
                head           <= '0;
                tail           <= '0;
                count          <= '0;
                busy           <= '0;
                ready          <= '0;
            end else begin
                if (alloc_fire) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    reg_dest[tail]   <= ID_reg_dest;
                    is_branch[tail]  <= ID_is_branch;
                    pred_taken[tail] <= ID_pred_taken;
                    tail             <= tail + TAG_W'(1);
                end
                if (LSB_valid && busy[LSB_tag]) begin
                    ready[LSB_tag] <= 1'b1;
                    data[LSB_tag]  <= LSB_data;
                end
                if (ALU_valid && busy[ALU_tag]) begin
                    ready[ALU_tag]  <= 1'b1;
                    data[ALU_tag]   <= ALU_data;
                    taken[ALU_tag]  <= ALU_taken;
                    target[ALU_tag] <= ALU_target;
                end
                if (commit_fire) begin
                    ROB_data_valid <= 1'b1;
                    ROB_reg_dest   <= reg_dest[head];
                    ROB_tag        <= head;
                    ROB_data       <= data[head];
                    busy[head]     <= 1'b0;
                    ready[head]    <= 1'b0;
                    head           <= head + TAG_W'(1);
                end
                count <= count + (TAG_W + 1)'(alloc_fire) - (TAG_W + 1)'(commit_fire);
            end
        end
    end

endmodule
